// File: rtl/keypad_entry_controller.sv
// Keypad front end: assembles a 4-bit code from key events, submits it to the authorization
// checker, and enforces a timed lockout after repeated denials.
module keypad_entry_controller #(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned ENTRY_TIMEOUT  = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  input  logic       auth_status,
  output logic [3:0] code,
  output logic       validate,
  output logic       granted,
  output logic       denied,
  output logic       locked,
  output logic [2:0] fail_count
);

  localparam int unsigned TW = (ENTRY_TIMEOUT > 1) ? $clog2(ENTRY_TIMEOUT) : 1;
  localparam int unsigned LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDigit  = 3'd1;
  localparam logic [2:0] StSubmit = 3'd2;
  localparam logic [2:0] StCheck  = 3'd3;
  localparam logic [2:0] StLocked = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic          validate_q, validate_d;
  logic          granted_q, granted_d;
  logic          denied_q, denied_d;
  logic          locked_q, locked_d;
  logic [2:0]    fail_q, fail_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;

  logic is_digit, is_clear, is_enter, lock_now;

  // Values other than digits, CLEAR and ENTER behave exactly like no key at all.
  assign is_digit = key_valid && (key_value <= 4'd9);
  assign is_clear = key_valid && (key_value == 4'hC);
  assign is_enter = key_valid && (key_value == 4'hE);
  assign lock_now = ({29'd0, fail_q} + 32'd1) >= MAX_FAILS;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    validate_d = 1'b0;
    granted_d  = 1'b0;
    denied_d   = 1'b0;
    locked_d   = locked_q;
    fail_d     = fail_q;
    tcnt_d     = tcnt_q;
    lcnt_d     = lcnt_q;
    unique case (state_q)
      StIdle: begin
        if (is_digit) begin
          code_d  = key_value;
          tcnt_d  = '0;
          state_d = StDigit;
        end
      end
      StDigit: begin
        if (is_digit) begin
          code_d = key_value;
          tcnt_d = '0;
        end else if (is_clear) begin
          code_d  = 4'd0;
          state_d = StIdle;
        end else if (is_enter) begin
          validate_d = 1'b1;
          state_d    = StSubmit;
        end else if (tcnt_q == TW'(ENTRY_TIMEOUT - 1)) begin
          code_d  = 4'd0;
          tcnt_d  = '0;
          state_d = StIdle;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StSubmit: state_d = StCheck;
      StCheck: begin
        code_d = 4'd0;
        if (auth_status) begin
          granted_d = 1'b1;
          fail_d    = 3'd0;
          state_d   = StIdle;
        end else if (lock_now) begin
          denied_d = 1'b1;
          fail_d   = 3'(MAX_FAILS);
          locked_d = 1'b1;
          lcnt_d   = '0;
          state_d  = StLocked;
        end else begin
          denied_d = 1'b1;
          fail_d   = fail_q + 3'd1;
          state_d  = StIdle;
        end
      end
      StLocked: begin
        code_d = 4'd0;
        if (lcnt_q == LW'(LOCKOUT_CYCLES - 1)) begin
          locked_d = 1'b0;
          fail_d   = 3'd0;
          lcnt_d   = '0;
          state_d  = StIdle;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: begin
        code_d  = 4'd0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      code_q     <= 4'd0;
      validate_q <= 1'b0;
      granted_q  <= 1'b0;
      denied_q   <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= 3'd0;
      tcnt_q     <= '0;
      lcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      validate_q <= validate_d;
      granted_q  <= granted_d;
      denied_q   <= denied_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
      tcnt_q     <= tcnt_d;
      lcnt_q     <= lcnt_d;
    end
  end

  assign code       = code_q;
  assign validate   = validate_q;
  assign granted    = granted_q;
  assign denied     = denied_q;
  assign locked     = locked_q;
  assign fail_count = fail_q;

endmodule
